seven_seg_scroll_ascii: RTL and testbench

Parametrised ASCII seven-segment driver with an internal message buffer and horizontal scrolling. Text is loaded one character at a time over a valid/ready write port. Messages longer than the display window scroll circularly at a fixed rate; shorter ones are shown static. It sits between user logic and the board's multiplexed seven-segment pins, and reuses `seven_seg_ascii_decoder` for glyph lookup.

---
 rtl/seven_seg_scroll_ascii.sv | 230 +++++++++++++++++++++++
 tb/tb_seven_seg_scroll_ascii.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scroll_ascii.sv
// Scrolling ASCII seven-segment driver with a loadable message buffer.
// Optional blink support is built when SEVEN_SEG_BLINK_EN is defined.
module seven_seg_ascii_decoder (
    input  logic [7:0] i_char,
    output logic [6:0] o_seg
);
    logic [7:0] w_up;
    logic [6:0] w_on;

    always_comb begin
        w_up = i_char;
        if (i_char >= 8'h61 && i_char <= 8'h7A) begin
            w_up = i_char - 8'h20;
        end
    end

    // Active-high {g,f,e,d,c,b,a}; unknown characters are blank.
    always_comb begin
        w_on = 7'h00;
        case (w_up)
            "0": w_on = 7'h3F;
            "1": w_on = 7'h06;
            "2": w_on = 7'h5B;
            "3": w_on = 7'h4F;
            "4": w_on = 7'h66;
            "5": w_on = 7'h6D;
            "6": w_on = 7'h7D;
            "7": w_on = 7'h07;
            "8": w_on = 7'h7F;
            "9": w_on = 7'h6F;
            "A": w_on = 7'h77;
            "B": w_on = 7'h7C;
            "C": w_on = 7'h39;
            "D": w_on = 7'h5E;
            "E": w_on = 7'h79;
            "F": w_on = 7'h71;
            "G": w_on = 7'h3D;
            "H": w_on = 7'h76;
            "I": w_on = 7'h30;
            "J": w_on = 7'h1E;
            "K": w_on = 7'h75;
            "L": w_on = 7'h38;
            "M": w_on = 7'h37;
            "N": w_on = 7'h54;
            "O": w_on = 7'h5C;
            "P": w_on = 7'h73;
            "Q": w_on = 7'h67;
            "R": w_on = 7'h50;
            "S": w_on = 7'h6D;
            "T": w_on = 7'h78;
            "U": w_on = 7'h3E;
            "V": w_on = 7'h1C;
            "W": w_on = 7'h2A;
            "X": w_on = 7'h49;
            "Y": w_on = 7'h6E;
            "Z": w_on = 7'h5B;
            "-": w_on = 7'h40;
            "_": w_on = 7'h08;
            default: w_on = 7'h00;
        endcase
    end

    assign o_seg = ~w_on;
endmodule

module seven_seg_scroll_ascii #(
    parameter int DISPLAY_COUNT = 4,
    parameter int MSG_DEPTH     = 32,
    parameter int SOURCE_FREQ   = 100_000_000,
    parameter int REFRESH_HZ    = 1000,
    parameter int SCROLL_HZ     = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_wr_valid,
    output logic                     o_wr_ready,
    input  logic [7:0]               i_wr_char,
    input  logic                     i_wr_last,
    input  logic                     i_scroll_en,
    input  logic                     i_blink,
    output logic [6:0]               o_segments,
    output logic [DISPLAY_COUNT-1:0] o_enable
);
    localparam int DIG_PER = SOURCE_FREQ / (REFRESH_HZ * DISPLAY_COUNT);
    localparam int SCR_PER = SOURCE_FREQ / SCROLL_HZ;
    localparam int DW  = (DIG_PER > 1) ? $clog2(DIG_PER) : 1;
    localparam int SCW = (SCR_PER > 1) ? $clog2(SCR_PER) : 1;
    localparam int SW  = $clog2(DISPLAY_COUNT);
    localparam int AW  = $clog2(MSG_DEPTH);
    localparam int CW  = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHOW
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CW-1:0]        r_count;
    logic [CW-1:0]        r_len;
    logic [AW-1:0]        r_off;
    logic [7:0]           r_buf [MSG_DEPTH];
    logic [DW-1:0]        r_div;
    logic [SW-1:0]        r_scan;
    logic                 r_upd;
    logic [SCW-1:0]       r_st;
    logic [6:0]           r_seg;
    logic [DISPLAY_COUNT-1:0] r_en;

    logic          w_xfer;
    logic          w_first;
    logic          w_commit;
    logic [CW-1:0] w_cnt_nxt;
    logic [AW-1:0] w_wr_idx;
    logic          w_dig_tick;
    logic          w_scr_tick;
    logic          w_scroll;
    logic [CW-1:0] w_off_inc;
    logic [CW-1:0] w_pos;
    logic [CW-1:0] w_sum;
    logic [CW-1:0] w_wrap;
    logic          w_space;
    logic [7:0]    w_char;
    logic [6:0]    w_glyph;
    logic          w_blink_off;
    logic          w_unused;

    assign o_wr_ready = 1'b1;
    assign w_xfer     = i_wr_valid & o_wr_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_first     = w_xfer && (r_state != S_LOAD);
        w_cnt_nxt   = w_first ? CW'(1) : r_count + CW'(1);
        w_commit    = w_xfer && (i_wr_last || (w_cnt_nxt == CW'(MSG_DEPTH)));
        if (w_commit) begin
            w_state_nxt = S_SHOW;
        end else if (w_xfer) begin
            w_state_nxt = S_LOAD;
        end
    end

    assign w_wr_idx = w_first ? '0 : r_count[AW-1:0];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_len   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_xfer) r_count <= w_cnt_nxt;
            if (w_commit) r_len <= w_cnt_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_xfer) r_buf[w_wr_idx] <= i_wr_char;
    end

    // Scroll timer free-runs; only a commit realigns it.
    assign w_scr_tick = (r_st == SCW'(SCR_PER - 1));
    assign w_scroll   = (r_state == S_SHOW) && w_scr_tick && i_scroll_en
                        && (r_len > CW'(DISPLAY_COUNT));
    assign w_off_inc  = {1'b0, r_off} + CW'(1);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_st  <= '0;
            r_off <= '0;
        end else begin
            r_st <= (w_commit || w_scr_tick) ? '0 : r_st + SCW'(1);
            if (w_commit) begin
                r_off <= '0;
            end else if (w_scroll) begin
                r_off <= (w_off_inc == r_len) ? '0 : w_off_inc[AW-1:0];
            end
        end
    end

    assign w_dig_tick = (r_div == DW'(DIG_PER - 1));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_div  <= '0;
            r_scan <= '0;
            r_upd  <= 1'b1;
        end else begin
            r_div <= w_dig_tick ? '0 : r_div + DW'(1);
            r_upd <= w_dig_tick;
            if (w_dig_tick) begin
                r_scan <= (r_scan == SW'(DISPLAY_COUNT - 1)) ? '0 : r_scan + SW'(1);
            end
        end
    end

    // Scan index s drives anode s, which is window position DISPLAY_COUNT-1-s.
    assign w_pos   = CW'(DISPLAY_COUNT - 1) - CW'(r_scan);
    assign w_sum   = {1'b0, r_off} + w_pos;
    assign w_wrap  = (w_sum >= r_len) ? w_sum - r_len : w_sum;
    assign w_space = (r_len <= CW'(DISPLAY_COUNT)) && (w_pos >= r_len);
    assign w_char  = w_space ? 8'h20 : r_buf[w_wrap[AW-1:0]];

    seven_seg_ascii_decoder u_dec (
        .i_char (w_char),
        .o_seg  (w_glyph)
    );

`ifdef SEVEN_SEG_BLINK_EN
    assign w_blink_off = i_blink && (r_st >= SCW'(SCR_PER / 2));
    assign w_unused    = w_wrap[CW-1];
`else
    assign w_blink_off = 1'b0;
    assign w_unused    = ^{w_wrap[CW-1], i_blink};
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_seg <= 7'h7F;
            r_en  <= '1;
        end else if (r_upd) begin
            r_en  <= ~(DISPLAY_COUNT'(1) << r_scan);
            r_seg <= ((r_state == S_SHOW) && !w_blink_off) ? w_glyph : 7'h7F;
        end
    end

    assign o_segments = r_seg;
    assign o_enable   = r_en;
endmodule

// File: tb/tb_seven_seg_scroll_ascii.sv
// Bench for seven_seg_scroll_ascii: queue-based display model plus
// directed frame pins and randomized loads.
module tb_seven_seg_scroll_ascii;
    localparam int DC    = 4;
    localparam int DEPTH = 8;
    localparam int DIG   = 4;
    localparam int SCR   = 64;

    localparam logic [6:0] G_SP = 7'h7F;
    localparam logic [6:0] G_H  = 7'h09;
    localparam logic [6:0] G_I  = 7'h4F;
    localparam logic [6:0] G_A  = 7'h08;
    localparam logic [6:0] G_B  = 7'h03;
    localparam logic [6:0] G_C  = 7'h46;
    localparam logic [6:0] G_D  = 7'h21;
    localparam logic [6:0] G_E  = 7'h06;
    localparam logic [6:0] G_F  = 7'h0E;
    localparam logic [6:0] G_Z  = 7'h24;
    localparam logic [6:0] G_0  = 7'h40;
    localparam logic [6:0] G_1  = 7'h79;
    localparam logic [6:0] G_2  = 7'h24;
    localparam logic [6:0] G_3  = 7'h30;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_char;
    logic       wr_last;
    logic       scroll_en;
    logic       blink;
    logic [6:0] seg;
    logic [3:0] en;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit started  = 0;

    seven_seg_scroll_ascii #(
        .DISPLAY_COUNT (DC),
        .MSG_DEPTH     (DEPTH),
        .SOURCE_FREQ   (64),
        .REFRESH_HZ    (4),
        .SCROLL_HZ     (1)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_wr_valid  (wr_valid),
        .o_wr_ready  (wr_ready),
        .i_wr_char   (wr_char),
        .i_wr_last   (wr_last),
        .i_scroll_en (scroll_en),
        .i_blink     (blink),
        .o_segments  (seg),
        .o_enable    (en)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [6:0] glyph(input logic [7:0] c);
        case (c)
            " ": return 7'h7F;
            "0": return 7'h40;
            "1": return 7'h79;
            "2": return 7'h24;
            "3": return 7'h30;
            "4": return 7'h19;
            "5": return 7'h12;
            "6": return 7'h02;
            "7": return 7'h78;
            "8": return 7'h00;
            "9": return 7'h10;
            "A": return 7'h08;
            "B": return 7'h03;
            "C": return 7'h46;
            "D": return 7'h21;
            "E": return 7'h06;
            "F": return 7'h0E;
            "H": return 7'h09;
            "I": return 7'h4F;
            "L": return 7'h47;
            "P": return 7'h0C;
            "U": return 7'h41;
            "Z": return 7'h24;
            "-": return 7'h3F;
            default: return 7'h7F;
        endcase
    endfunction

    // Model: message as a queue, time counted in edges since reset release.
    logic [7:0] m_q[$];
    bit         m_loading;
    bit         m_show;
    int         m_len;
    int         m_off;
    int         m_c;
    int         m_t;
    logic [6:0] exp_seg;
    logic [3:0] exp_en;

    function automatic logic [7:0] char_at(input int pos);
        if (m_len <= DC) return (pos < m_len) ? m_q[pos] : 8'h20;
        return m_q[(m_off + pos) % m_len];
    endfunction

    always @(posedge clk) begin
        int s;
        bit boff;
        if (rst) begin
            m_q.delete();
            m_loading = 0;
            m_show    = 0;
            m_len     = 0;
            m_off     = 0;
            m_c       = 0;
            m_t       = 0;
            exp_seg   = 7'h7F;
            exp_en    = 4'hF;
        end else begin
            m_t++;
            if ((m_t - 1) % DIG == 0) begin
                s = ((m_t - 1) / DIG) % DC;
                exp_en = ~(4'b0001 << s);
                boff = 0;
`ifdef SEVEN_SEG_BLINK_EN
                if (m_show) boff = blink && (((m_t - 1 - m_c) % SCR) >= SCR / 2);
`endif
                exp_seg = (m_show && !boff) ? glyph(char_at(DC - 1 - s)) : 7'h7F;
            end
            if (m_show && m_len > DC && scroll_en && ((m_t - m_c) % SCR == 0))
                m_off = (m_off + 1) % m_len;
            if (wr_valid) begin
                if (!m_loading) m_q.delete();
                m_q.push_back(wr_char);
                if (wr_last || m_q.size() == DEPTH) begin
                    m_len     = m_q.size();
                    m_off     = 0;
                    m_c       = m_t;
                    m_show    = 1;
                    m_loading = 0;
                end else begin
                    m_loading = 1;
                    m_show    = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            if (rst) begin
                checks++;
                if (seg !== 7'h7F || en !== 4'hF) begin
                    failures++;
                    $display("FAIL reset_out: seg=%h en=%b want 7f/1111 t=%0t",
                             seg, en, $time);
                end
            end else begin
                checks++;
                if (seg !== exp_seg || en !== exp_en || wr_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL cycle: seg=%h en=%b rdy=%b want %h/%b/1 t=%0t",
                             seg, en, wr_ready, exp_seg, exp_en, $time);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(posedge clk);
        #2;
    endtask

    task automatic send(input string s, input bit last);
        for (int k = 0; k < s.len(); k++) begin
            wr_valid = 1'b1;
            wr_char  = s[k];
            wr_last  = last && (k == s.len() - 1);
            tick();
        end
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic pin_frame(input string name, input logic [6:0] p0,
                             input logic [6:0] p1, input logic [6:0] p2,
                             input logic [6:0] p3);
        logic [6:0] want [4];
        int pos;
        want = '{p0, p1, p2, p3};
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            pos = 0;
            for (int b = 0; b < 4; b++) if (!exp_en[b]) pos = 3 - b;
            checks++;
            if (exp_seg !== want[pos]) begin
                failures++;
                $display("FAIL model_%s pos%0d: got %h want %h", name, pos,
                         exp_seg, want[pos]);
            end
            checks++;
            if (seg !== want[pos]) begin
                failures++;
                $display("FAIL dut_%s pos%0d: got %h want %h", name, pos,
                         seg, want[pos]);
            end
        end
    endtask

    task automatic pin_scan(input string name, input logic [3:0] want);
        checks++;
        if (en !== want || seg !== 7'h7F) begin
            failures++;
            $display("FAIL %s: en=%b seg=%h want %b/7f", name, en, seg, want);
        end
    endtask

    initial begin
        string alpha;
        int tc;
        int r;
        int n;
        alpha     = " 0123456789ABCDEFHILPUZ-";
        rst       = 1'b1;
        wr_valid  = 1'b0;
        wr_char   = 8'h00;
        wr_last   = 1'b0;
        scroll_en = 1'b1;
        blink     = 1'b0;
        #1 started = 1;
        repeat (3) tick();
        rst = 1'b0;

        @(posedge clk);
        @(negedge clk);
        pin_scan("scan0", 4'b1110);
        repeat (4) @(negedge clk);
        pin_scan("scan1", 4'b1101);
        repeat (4) @(negedge clk);
        pin_scan("scan2", 4'b1011);
        repeat (4) @(negedge clk);
        pin_scan("scan3", 4'b0111);
        repeat (10) tick();

        send("HI", 1);
        tc = cyc;
        wait_to(tc + 8);
        pin_frame("hi", G_H, G_I, G_SP, G_SP);
        wait_to(tc + 3 * SCR + 8);
        pin_frame("hi_3p", G_H, G_I, G_SP, G_SP);
        blink = 1'b1;
        wait_to(tc + 4 * SCR + 8);
        pin_frame("blink_on", G_H, G_I, G_SP, G_SP);
        wait_to(tc + 4 * SCR + 40);
`ifdef SEVEN_SEG_BLINK_EN
        pin_frame("blink_off", G_SP, G_SP, G_SP, G_SP);
`else
        pin_frame("blink_off", G_H, G_I, G_SP, G_SP);
`endif
        blink = 1'b0;
        repeat (5) tick();

        send("ABCDEF", 1);
        tc = cyc;
        wait_to(tc + 8);
        pin_frame("abcd", G_A, G_B, G_C, G_D);
        wait_to(tc + SCR + 8);
        pin_frame("bcde", G_B, G_C, G_D, G_E);
        wait_to(tc + 5 * SCR + 8);
        pin_frame("fabc", G_F, G_A, G_B, G_C);
        wait_to(tc + 350);
        scroll_en = 1'b0;
        wait_to(tc + 350 + 2 * SCR);
        pin_frame("frozen", G_F, G_A, G_B, G_C);
        scroll_en = 1'b1;
        repeat (3) tick();

        send("01234567", 0);
        tc = cyc;
        wait_to(tc + 8);
        pin_frame("auto", G_0, G_1, G_2, G_3);
        send("L", 0);
        tc = cyc;
        wait_to(tc + 8);
        pin_frame("reload", G_SP, G_SP, G_SP, G_SP);

        send("PUL", 0);
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (6) tick();
        send("Z", 1);
        tc = cyc;
        wait_to(tc + 8);
        pin_frame("z", G_Z, G_SP, G_SP, G_SP);

        for (int it = 0; it < 180; it++) begin
            r = $urandom_range(0, 99);
            if (r < 4) begin
                rst = 1'b1;
                repeat (2) tick();
                rst = 1'b0;
            end else begin
                n = $urandom_range(1, 10);
                for (int k = 0; k < n; k++) begin
                    wr_valid = 1'b1;
                    wr_char  = alpha[$urandom_range(0, 23)];
                    wr_last  = (k == n - 1) && ($urandom_range(0, 4) != 0);
                    tick();
                    wr_valid = 1'b0;
                    wr_last  = 1'b0;
                    repeat ($urandom_range(0, 2)) tick();
                end
            end
            scroll_en = ($urandom_range(0, 3) != 0);
            blink     = $urandom_range(0, 1) == 1;
            repeat ($urandom_range(4, 160)) tick();
        end

        repeat (4) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
